// File: rtl/uart_pkg.sv
// Shared UART types: transmitter FSM states, parity mode codes and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Even mode sends the XOR of the data bits; odd mode sends its inverse.
  function automatic logic parity_bit(input logic [7:0] dat, input int mode);
    return (mode == PAR_ODD) ? ~^dat : ^dat;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; pop data is visible combinationally from the head entry (zero-cycle read).
// Backpressure: a push while full is dropped, even when a pop happens on the same edge; rdy_o is a flop equal to !full.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     rdy_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrp_q, rdp_q;
  logic [AW:0]      level_q, level_d;
  logic             rdy_q;
  logic             do_push, do_pop;

  assign full_o    = (level_q == FULL_LVL);
  assign empty_o   = (level_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rdp_q];
  assign level_o   = level_q;
  assign rdy_o     = rdy_q;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 1'b1;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrp_q   <= '0;
      rdp_q   <= '0;
      level_q <= '0;
      rdy_q   <= 1'b1;
    end else begin
      if (do_push) wrp_q <= wrp_q + 1'b1;
      if (do_pop)  rdp_q <= rdp_q + 1'b1;
      level_q <= level_d;
      rdy_q   <= (level_d != FULL_LVL);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wrp_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: a byte pushed into an empty FIFO while idle drives o_tx low one edge later.
// Backpressure: o_rdy drops while the FIFO is full; frames run back-to-back while bytes remain queued.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int FREQ      = 1_000_000,
  parameter int RATE      = 115_200,
  parameter int DEPTH     = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               i_data,
  input  logic                     i_vld,
  output logic                     o_rdy,
  output logic                     o_tx,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int DIV = FREQ / RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_e   state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        par_q;
  logic        tx_q;

  logic        fifo_full, fifo_empty, fifo_rdy;
  logic [7:0]  fifo_dat;
  logic        bit_end, stop_end, pop;

  assign bit_end  = (baud_q == BAUD_LAST);
  assign stop_end = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);
  assign pop      = !fifo_empty && ((state_q == S_IDLE) || stop_end);

  uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (i_vld && !fifo_full),
    .push_dat_i (i_data),
    .pop_i      (pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .rdy_o      (fifo_rdy),
    .level_o    (o_level)
  );

  assign o_rdy  = fifo_rdy;
  assign o_tx   = tx_q;
  assign o_busy = (state_q != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      baud_q <= bit_end ? '0 : baud_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          tx_q   <= 1'b1;
          if (pop) begin
            shift_q <= fifo_dat;
            par_q   <= parity_bit(fifo_dat, PARITY);
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            bit_q   <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              bit_q <= '0;
              if (PARITY != PAR_NONE) begin
                tx_q    <= par_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            bit_q   <= '0;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              // Chain straight into the next frame so the line never idles between queued bytes.
              if (pop) begin
                shift_q <= fifo_dat;
                par_q   <= parity_bit(fifo_dat, PARITY);
                tx_q    <= 1'b0;
                state_q <= S_START;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_IDLE;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Three transmitters (no parity/1 stop, even/2 stop, odd/1 stop) against a queue-based line model plus a mid-bit sampling receiver on instance 0.
module tb_uart_tx_buf;

  localparam int DIV   = 1_000_000 / 115_200;
  localparam int DEPTH = 8;
  localparam int N     = 3;

  int par_m [N] = '{0, 1, 2};
  int stp_m [N] = '{1, 2, 1};

  logic       clk;
  logic       rst_n;
  logic [7:0] i_data;
  logic       i_vld;
  logic [N-1:0] rdy, tx, busy;
  logic [3:0] lvl [N];

  uart_tx_buf #(.PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_vld(i_vld),
    .o_rdy(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_level(lvl[0]));
  uart_tx_buf #(.PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_vld(i_vld),
    .o_rdy(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_level(lvl[1]));
  uart_tx_buf #(.PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_vld(i_vld),
    .o_rdy(rdy[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_level(lvl[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: queued bytes, per-cycle pending line levels, current line and frame-active flag.
  logic [7:0] mq [N][$];
  logic       mw [N][$];
  logic       m_line [N];
  logic       m_act  [N];
  logic [7:0] rx_exp [$];

  bit         rx_on;
  int         rx_t;
  logic [7:0] rx_sh;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mq[k].delete();
      mw[k].delete();
      m_line[k] = 1'b1;
      m_act[k]  = 1'b0;
    end
    rx_exp.delete();
    rx_on = 0;
    rx_t  = 0;
  endtask

  task automatic add_bit(input int k, input logic b);
    for (int c = 0; c < DIV; c++) mw[k].push_back(b);
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d);
    logic       acc;
    logic [7:0] b;
    for (int k = 0; k < N; k++) begin
      acc = v && (mq[k].size() < DEPTH);
      if (mw[k].size() == 0 && mq[k].size() > 0) begin
        b = mq[k].pop_front();
        add_bit(k, 1'b0);
        for (int i = 0; i < 8; i++) add_bit(k, b[i]);
        if (par_m[k] == 1) add_bit(k, ^b);
        if (par_m[k] == 2) add_bit(k, ~^b);
        for (int s = 0; s < stp_m[k]; s++) add_bit(k, 1'b1);
      end
      if (mw[k].size() > 0) begin
        m_line[k] = mw[k].pop_front();
        m_act[k]  = 1'b1;
      end else begin
        m_line[k] = 1'b1;
        m_act[k]  = 1'b0;
      end
      if (acc) begin
        mq[k].push_back(d);
        if (k == 0) rx_exp.push_back(d);
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("tx%0d", k),    32'(tx[k]),   32'(m_line[k]));
      chk($sformatf("rdy%0d", k),   32'(rdy[k]),  32'(mq[k].size() < DEPTH));
      chk($sformatf("busy%0d", k),  32'(busy[k]), 32'(m_act[k] || (mq[k].size() > 0)));
      chk($sformatf("level%0d", k), 32'(lvl[k]),  32'(mq[k].size()));
    end
  endtask

  // Independent receiver on instance 0: sample each bit at its centre after the start edge.
  task automatic rx_sample();
    int j;
    if (!rx_on) begin
      if (tx[0] == 1'b0) begin
        rx_on = 1;
        rx_t  = 0;
      end
    end else begin
      rx_t++;
    end
    if (rx_on && (rx_t % DIV == DIV / 2)) begin
      j = rx_t / DIV;
      if (j == 0) chk("rx_start", 32'(tx[0]), 32'd0);
      else if (j <= 8) rx_sh[j-1] = tx[0];
      else begin
        chk("rx_stop", 32'(tx[0]), 32'd1);
        chk("rx_expected", 32'(rx_exp.size() > 0), 32'd1);
        if (rx_exp.size() > 0) chk("rx_byte", 32'(rx_sh), 32'(rx_exp.pop_front()));
        rx_on = 0;
      end
    end
  endtask

  // Called at a falling edge: drive inputs for the next rising edge, then check after it.
  task automatic cycle(input logic v, input logic [7:0] d);
    i_vld  = v;
    i_data = d;
    model_edge(v, d);
    @(negedge clk);
    compare();
    rx_sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    i_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    compare();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    i_vld  = 1'b0;
    i_data = 8'h00;
    rst_n  = 1'b0;
    model_reset();
    @(negedge clk);
    compare();
    @(negedge clk);
    rst_n = 1'b1;

    // Single 0x6A frame from idle.
    cycle(1'b1, 8'h6A);
    idle(110);

    // Burst past the FIFO depth; refused bytes must never appear on the line.
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'hA0 + i));
    idle(1100);

    // Random traffic with varying density.
    for (int i = 0; i < 2500; i++) begin
      cycle(($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 4 : 30)), 8'($urandom));
    end
    idle(1100);

    // Reset during the data bits of 0x55 with three more bytes queued.
    cycle(1'b1, 8'h55);
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h22);
    cycle(1'b1, 8'h33);
    idle(16);
    chk("pre_reset_tx0", 32'(tx[0]), 32'd0);
    do_reset();
    idle(200);

    // Extremes plus the reference byte, read back by the receiver.
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'hFF);
    cycle(1'b1, 8'h6A);
    idle(400);
    chk("rx_pending", 32'(rx_exp.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
